// File: rtl/axis_frame_tx.sv
// AXI-Stream master that streams a preloaded buffer as one frame (TLAST on the final beat).
// Optional macro AXIS_FRAME_TX_GAP_EN inserts GAP idle cycles after each non-final beat.
module axis_frame_tx #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
`ifdef AXIS_FRAME_TX_GAP_EN
  ,
  parameter int GAP    = 2
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              M_AXIS_TVALID,
  output logic [DATA_W-1:0] M_AXIS_TDATA,
  output logic              M_AXIS_TLAST,
  input  logic              M_AXIS_TREADY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
`ifdef AXIS_FRAME_TX_GAP_EN
    S_GAP,
`endif
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_len;
  logic              r_busy;
  logic              r_done;
  logic              r_tvalid;
  logic              r_tlast;
  logic [DATA_W-1:0] r_tdata;
`ifdef AXIS_FRAME_TX_GAP_EN
  logic [7:0]        r_gap;
`endif

  logic              w_hs;
  logic              w_wr_ok;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic [ADDR_W:0]   w_len_clamp;

  assign w_hs        = r_tvalid & M_AXIS_TREADY;
  assign w_wr_ok     = wr_en & ~r_busy;
  assign w_ptr_nxt   = r_ptr + 1'b1;
  assign w_len_clamp = (len > LP_DEPTH) ? LP_DEPTH : len;

  // Buffer contents survive reset so a frame can be replayed after an abort.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_len    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
`ifdef AXIS_FRAME_TX_GAP_EN
      r_gap    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              r_len   <= w_len_clamp;
              r_ptr   <= '0;
              r_busy  <= 1'b1;
              r_state <= S_FETCH;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          r_tdata  <= r_mem[r_ptr];
          r_tvalid <= 1'b1;
          r_tlast  <= (r_len == LP_ONE);
          r_state  <= S_SEND;
        end
        S_SEND: begin
          if (w_hs) begin
            if (r_tlast) begin
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
              r_state  <= S_DONE;
            end else begin
              // Prefetch the next entry on the handshake edge: no bubble between beats.
              r_tdata <= r_mem[w_ptr_nxt];
              r_ptr   <= w_ptr_nxt;
              r_tlast <= (({1'b0, w_ptr_nxt} + LP_ONE) == r_len);
`ifdef AXIS_FRAME_TX_GAP_EN
              r_tvalid <= 1'b0;
              r_gap    <= 8'(GAP - 1);
              r_state  <= S_GAP;
`endif
            end
          end
        end
`ifdef AXIS_FRAME_TX_GAP_EN
        S_GAP: begin
          if (r_gap == '0) begin
            r_tvalid <= 1'b1;
            r_state  <= S_SEND;
          end else begin
            r_gap <= r_gap - 8'd1;
          end
        end
`endif
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign M_AXIS_TVALID = r_tvalid;
  assign M_AXIS_TDATA  = r_tdata;
  assign M_AXIS_TLAST  = r_tlast;

endmodule

// File: tb/tb_axis_frame_tx.sv
// Scoreboard bench for axis_frame_tx: expected beats queued at start, popped on each handshake.
module tb_axis_frame_tx;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic              tvalid;
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic              tready;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] sb_q [$];

  always #5 clk = ~clk;

  axis_frame_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .len(len), .busy(busy), .done(done),
    .M_AXIS_TVALID(tvalid), .M_AXIS_TDATA(tdata), .M_AXIS_TLAST(tlast),
    .M_AXIS_TREADY(tready)
  );

  task automatic write_mem(input int a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a[ADDR_W-1:0]; wr_data = d;
    model_mem[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic push_frame(input int l);
    int n;
    n = (l > DEPTH) ? DEPTH : l;
    for (int i = 0; i < n; i++) sb_q.push_back(model_mem[i]);
  endtask

  task automatic kick(input int l);
    @(negedge clk);
    start = 1'b1;
    len   = l[ADDR_W:0];
    push_frame(l);
  endtask

  // mode 0: always ready; mode 1: ready pattern 1,0,0,1,0 repeating.
  task automatic run_stream(input int mode, input int budget, input int stop_hs,
                            output int hs, output int busy_cyc, output int first_vld,
                            output int done_cyc, output int last_hs, output logic [63:0] vhist);
    bit stall;
    logic [DATA_W-1:0] pd, exp_d;
    logic pl;
    hs = 0; busy_cyc = 0; first_vld = -1; done_cyc = -1; last_hs = -1; vhist = '0;
    stall = 0; pd = '0; pl = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      tready = (mode == 0) ? 1'b1 : (((cyc % 5) == 0) || ((cyc % 5) == 3));
      if (busy) busy_cyc++;
      if (tvalid === 1'b1) begin
        if (cyc < 64) vhist[cyc] = 1'b1;
        if (first_vld < 0) first_vld = cyc;
      end
      if (stall) begin
        checks++;
        if (tvalid !== 1'b1 || tdata !== pd || tlast !== pl) begin
          failures++;
          $display("FAIL stall_hold cyc=%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   cyc, tvalid, tdata, tlast, pd, pl);
        end
      end
      if (tvalid === 1'b1 && tready) begin
        hs++;
        last_hs = cyc;
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL extra_beat got d=%h want no beat", tdata);
        end else begin
          exp_d = sb_q.pop_front();
          if (tdata !== exp_d || tlast !== (sb_q.size() == 0)) begin
            failures++;
            $display("FAIL beat%0d got d=%h l=%b want d=%h l=%b",
                     hs, tdata, tlast, exp_d, (sb_q.size() == 0));
          end
        end
      end
      stall = (tvalid === 1'b1) && !tready;
      pd = tdata;
      pl = tlast;
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (stop_hs > 0 && hs == stop_hs) break;
    end
    if (done_cyc < 0 && stop_hs == 0) begin
      checks++;
      failures++;
      $display("FAIL stream_timeout got no done within %0d cycles want done", budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; len = '0; tready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)   begin failures++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid got %b want 0", tvalid); end
    checks++; if (tdata !== '0)    begin failures++; $display("FAIL rst_tdata got %h want 00", tdata); end
    checks++; if (tlast !== 1'b0)  begin failures++; $display("FAIL rst_tlast got %b want 0", tlast); end
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) write_mem(i, DATA_W'(3 * i));
  endtask

  task automatic test_full_frame();
    int hs, bc, fv, dc, lh;
    logic [63:0] vh;
    kick(32);
    run_stream(0, 200, 0, hs, bc, fv, dc, lh, vh);
    checks++; if (hs != 32) begin failures++; $display("FAIL full_hs got %0d want 32", hs); end
    checks++; if (fv != 2)  begin failures++; $display("FAIL full_first_valid got %0d want 2", fv); end
    checks++; if (bc != 34) begin failures++; $display("FAIL full_busy_cycles got %0d want 34", bc); end
    checks++; if (vh[33:2] !== 32'hFFFF_FFFF) begin failures++; $display("FAIL full_b2b got %h want ffffffff", vh[33:2]); end
    checks++; if (dc != lh + 2) begin failures++; $display("FAIL full_done_cyc got %0d want %0d", dc, lh + 2); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL full_done_width got %b want 0", done); end
  endtask

  task automatic test_backpressure();
    int hs, bc, fv, dc, lh;
    logic [63:0] vh;
    kick(32);
    run_stream(1, 400, 0, hs, bc, fv, dc, lh, vh);
    checks++; if (hs != 32) begin failures++; $display("FAIL bp_hs got %0d want 32", hs); end
    checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL bp_leftover got %0d want 0", sb_q.size()); end
  endtask

  task automatic test_len_edges();
    int hs, bc, fv, dc, lh;
    logic [63:0] vh;
    write_mem(0, 8'hA5);
    kick(1);
    run_stream(0, 50, 0, hs, bc, fv, dc, lh, vh);
    checks++; if (hs != 1) begin failures++; $display("FAIL len1_hs got %0d want 1", hs); end
    kick(0);
    run_stream(0, 20, 0, hs, bc, fv, dc, lh, vh);
    checks++; if (dc != 1)  begin failures++; $display("FAIL len0_done_cyc got %0d want 1", dc); end
    checks++; if (fv != -1) begin failures++; $display("FAIL len0_tvalid got first=%0d want never", fv); end
    checks++; if (bc != 0)  begin failures++; $display("FAIL len0_busy got %0d want 0", bc); end
    write_mem(0, 8'h00);
    kick(40);
    run_stream(0, 200, 0, hs, bc, fv, dc, lh, vh);
    checks++; if (hs != 32) begin failures++; $display("FAIL len40_hs got %0d want 32", hs); end
  endtask

  task automatic test_write_and_start();
    int hs, bc, fv, dc, lh;
    logic [63:0] vh;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 8'h77; model_mem[3] = 8'h77;
    start = 1'b1; len = 6'd4;
    push_frame(4);
    run_stream(0, 50, 0, hs, bc, fv, dc, lh, vh);
    checks++; if (hs != 4) begin failures++; $display("FAIL wrstart_hs got %0d want 4", hs); end
    write_mem(3, 8'd9);
  endtask

  task automatic test_reset_mid();
    int hs, bc, fv, dc, lh;
    bit saw_done;
    logic [63:0] vh;
    kick(32);
    run_stream(0, 100, 5, hs, bc, fv, dc, lh, vh);
    checks++; if (hs != 5) begin failures++; $display("FAIL rmid_hs got %0d want 5", hs); end
    @(negedge clk);
    rst = 1'b1; tready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL rmid_tvalid got %b want 0", tvalid); end
    checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL rmid_busy got %b want 0", busy); end
    saw_done = (done === 1'b1);
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    checks++; if (saw_done) begin failures++; $display("FAIL rmid_done got pulse want none"); end
    sb_q.delete();
    kick(4);
    run_stream(0, 50, 0, hs, bc, fv, dc, lh, vh);
    checks++; if (hs != 4) begin failures++; $display("FAIL rmid_restart_hs got %0d want 4", hs); end
  endtask

  task automatic test_wr_busy();
    int hs, bc, fv, dc, lh;
    logic [63:0] vh;
    kick(4);
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wrbusy_busy got %b want 1", busy); end
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 8'hFF;
    run_stream(0, 50, 0, hs, bc, fv, dc, lh, vh);
    kick(4);
    run_stream(0, 50, 0, hs, bc, fv, dc, lh, vh);
    checks++; if (hs != 4) begin failures++; $display("FAIL wrbusy_hs got %0d want 4", hs); end
  endtask

`ifdef AXIS_FRAME_TX_GAP_EN
  task automatic test_gap();
    int hs, bc, fv, dc, lh;
    logic [63:0] vh;
    kick(3);
    run_stream(0, 50, 0, hs, bc, fv, dc, lh, vh);
    checks++; if (vh[8:2] !== 7'b1001001) begin failures++; $display("FAIL gap_pattern got %b want 1001001", vh[8:2]); end
    checks++; if (hs != 3) begin failures++; $display("FAIL gap_hs got %0d want 3", hs); end
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_len_edges();
    test_write_and_start();
    test_reset_mid();
    test_wr_busy();
`ifdef AXIS_FRAME_TX_GAP_EN
    test_gap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish before 500us");
    $fatal(1, "watchdog");
  end

endmodule
